// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. Only one transaction is in flight on the memory
//   port at a time: grant (IDLE) -> address accept (REQ) -> data return (WAIT).
//
//   Data requests win by default. The fetch side is protected from starvation
//   by starve_cnt: after STARVE_LIMIT consecutive data grants made while
//   inst_req was waiting, the next grant goes to the fetch side.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   inst_req, inst_addr               fetch request (read, word)
//   inst_addr_ok, inst_data_ok        fetch accept / return strobes
//   inst_rdata                        fetched word, valid with inst_data_ok
//   data_req, data_wr, data_size,
//   data_wstrb, data_addr, data_wdata load/store request
//   data_addr_ok, data_data_ok        load/store accept / completion strobes
//   data_rdata                        load data, valid with data_data_ok
//   mem_req .. mem_wdata              shared memory port request
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                         shared memory port responses
//   dbg_state                         FSM state (0=IDLE, 1=REQ, 2=WAIT)
//
// Handshake: a requester holds req and its fields until its addr_ok pulse
// (single cycle, asserted while the block is in REQ and mem_addr_ok is high).
// Once granted, the transaction is latched; dropping req afterwards does not
// cancel it. data_ok pulses for one cycle in WAIT when mem_data_ok is high.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Wide enough to hold STARVE_LIMIT itself, and never zero bits wide.
  localparam int            CW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic          owner_q;      // 1 = data requester, 0 = fetch requester
  logic          wr_q;
  logic [1:0]    size_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          grant_inst;
  logic          grant_data;

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state_q == S_IDLE) begin
      if (inst_req && (starve_cnt == LIMIT)) begin
        grant_inst = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. mem_data_ok outside WAIT is ignored; in REQ an
  // accept takes precedence and the return is expected later in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_inst || grant_data) state_d = S_REQ;
      S_REQ:   if (mem_addr_ok)              state_d = S_WAIT;
      S_WAIT:  if (mem_data_ok)              state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Transaction latch and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      wstrb_q    <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      starve_cnt <= '0;
    end else if (grant_data) begin
      owner_q <= 1'b1;
      wr_q    <= data_wr;
      size_q  <= data_size;
      wstrb_q <= data_wstrb;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
      if (!inst_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else if (grant_inst) begin
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd2;
      wstrb_q    <= 4'd0;
      addr_q     <= inst_addr;
      wdata_q    <= 32'd0;
      starve_cnt <= '0;
    end
  end

  // Outputs. Strobes are routed to the owner only; rdata is gated so that
  // everything reads 0 while reset holds the block in IDLE.
  always_comb begin
    mem_req      = (state_q == S_REQ);
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_wstrb    = wstrb_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    inst_addr_ok = (state_q == S_REQ)  && mem_addr_ok && !owner_q;
    data_addr_ok = (state_q == S_REQ)  && mem_addr_ok &&  owner_q;
    inst_data_ok = (state_q == S_WAIT) && mem_data_ok && !owner_q;
    data_data_ok = (state_q == S_WAIT) && mem_data_ok &&  owner_q;
    inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    data_rdata   = data_data_ok ? mem_rdata : 32'd0;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int         STARVE_LIMIT = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [141:0] all_outs;
  assign all_outs = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
                     data_rdata, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr,
                     mem_wdata, dbg_state};

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        owner;   // 1 = data
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // ---------------- driver tasks ----------------
  task automatic push_inst(input logic [31:0] addr, input logic [31:0] rd);
    exp_t e;
    e = '{owner: 1'b0, wr: 1'b0, size: 2'd2, wstrb: 4'd0, addr: addr, wdata: 32'd0, rdata: rd};
    exp_q.push_back(e);
  endtask

  task automatic push_data(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd);
    exp_t e;
    e = '{owner: 1'b1, wr: wr, size: size, wstrb: wstrb, addr: addr, wdata: wdata, rdata: rd};
    exp_q.push_back(e);
  endtask

  task automatic drive_data(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                            input logic [31:0] addr, input logic [31:0] wdata);
    data_req = 1'b1; data_wr = wr; data_size = size; data_wstrb = wstrb;
    data_addr = addr; data_wdata = wdata;
  endtask

  // Waits (bounded) for mem_req at negedges; n = negedges spent before it.
  task automatic wait_mem_req(output int n);
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Memory responder: holds off accept for 'delay' cycles, then accepts and
  // returns the scoreboard's read data one cycle later.
  // drop_mode: 0 keep req, 1 drop owner req after accept, 2 drop at grant.
  task automatic serve(input int delay, input int drop_mode, output int lat);
    exp_t e;
    wait_mem_req(lat);
    checks++;
    if (!mem_req || exp_q.size() == 0) begin
      $display("FAIL grant_timeout: mem_req=%0b queued=%0d required mem_req=1 with entry",
               mem_req, exp_q.size());
      return;
    end
    passes++;
    e = exp_q.pop_front();
    checks++;
    if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== {e.wr, e.size, e.wstrb, e.addr, e.wdata})
      $display("FAIL grant_fields: got wr=%0b size=%0d wstrb=%h addr=%h wdata=%h required wr=%0b size=%0d wstrb=%h addr=%h wdata=%h",
               mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, e.wr, e.size, e.wstrb, e.addr, e.wdata);
    else passes++;
    if (drop_mode == 2) begin
      if (e.owner) begin data_req = 1'b0; data_addr = ~data_addr; end
      else begin inst_req = 1'b0; inst_addr = ~inst_addr; end
    end
    for (int i = 0; i < delay; i++) begin
      checks++;
      if ({mem_req, mem_addr, mem_wdata, mem_wstrb, inst_addr_ok, data_addr_ok} !==
          {1'b1, e.addr, e.wdata, e.wstrb, 1'b0, 1'b0})
        $display("FAIL backpressure_hold cycle %0d: mem_req=%0b addr=%h aok=%0b/%0b required 1 %h 0/0",
                 i, mem_req, mem_addr, inst_addr_ok, data_addr_ok, e.addr);
      else passes++;
      @(negedge clk);
    end
    mem_addr_ok = 1'b1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== (e.owner ? 2'b01 : 2'b10))
      $display("FAIL addr_ok_owner: inst/data=%0b%0b required %0b%0b",
               inst_addr_ok, data_addr_ok, !e.owner, e.owner);
    else passes++;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0;
    if (drop_mode == 1) begin
      if (e.owner) data_req = 1'b0; else inst_req = 1'b0;
    end
    @(negedge clk);
    mem_data_ok = 1'b1;
    mem_rdata   = e.rdata;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, (e.owner ? data_rdata : inst_rdata)} !==
        {!e.owner, e.owner, e.rdata})
      $display("FAIL data_return: inst/data_ok=%0b%0b rdata=%h required %0b%0b %h",
               inst_data_ok, data_data_ok, (e.owner ? data_rdata : inst_rdata),
               !e.owner, e.owner, e.rdata);
    else passes++;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; inst_addr = $urandom;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    #1;
    checks++;
    if (all_outs !== '0) $display("FAIL reset_outputs: got %h required 0", all_outs);
    else passes++;
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_inst_only;
    int lat;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    push_inst(32'h1C00_0000, 32'h0280_0C0C);
    serve(0, 1, lat);
    checks++;
    if (lat !== 1) $display("FAIL first_grant_latency: got %0d required 1", lat);
    else passes++;
  endtask

  task automatic test_simultaneous;
    int lat;
    push_data(1'b1, 2'd2, 4'hF, 32'h1C00_1000, 32'hDEAD_BEEF, 32'h0);
    push_inst(32'h1C00_0004, 32'h1234_5678);
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    drive_data(1'b1, 2'd2, 4'hF, 32'h1C00_1000, 32'hDEAD_BEEF);
    serve(0, 1, lat);
    serve(0, 1, lat);
    checks++;
    if (lat !== 1) $display("FAIL back_to_back_latency: got %0d required 1", lat);
    else passes++;
  endtask

  task automatic test_starvation;
    int lat;
    logic [31:0] da;
    da = 32'h1C00_2000 + (32'($urandom_range(0, 255)) << 2);
    push_data(1'b0, 2'd2, 4'hF, da, 32'h0, 32'h1111_0000);
    push_data(1'b0, 2'd2, 4'hF, da, 32'h0, 32'h2222_0000);
    push_inst(32'h1C00_0040, 32'h3333_0000);
    push_data(1'b0, 2'd2, 4'hF, da, 32'h0, 32'h4444_0000);
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    drive_data(1'b0, 2'd2, 4'hF, da, 32'h0);
    serve(0, 0, lat);
    serve(0, 0, lat);
    serve(0, 1, lat);
    serve(0, 1, lat);
    checks++;
    if (lat !== 1) $display("FAIL starvation_latency: got %0d required 1", lat);
    else passes++;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [31:0] a, w;
    a = $urandom; w = $urandom;
    push_data(1'b1, 2'd0, 4'h2, a, w, $urandom);
    drive_data(1'b1, 2'd0, 4'h2, a, w);
    serve(5, 2, lat);
  endtask

  task automatic test_spurious;
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = $urandom;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00)
      $display("FAIL spurious_strobe: got %0b%0b required 00", inst_data_ok, data_data_ok);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL spurious_state: got %0d required %0d", dbg_state, ST_IDLE);
    else passes++;
    mem_data_ok = 1'b0;
  endtask

  task automatic test_accept_and_return;
    int n;
    inst_req = 1'b1; inst_addr = 32'h1C00_0080;
    wait_mem_req(n);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b110)
      $display("FAIL accept_only: req/aok/dok=%0b%0b%0b required 110", mem_req, inst_addr_ok, inst_data_ok);
    else passes++;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({dbg_state, inst_data_ok, inst_rdata} !== {ST_WAIT, 1'b1, 32'h0BAD_F00D})
      $display("FAIL accept_then_return: state=%0d dok=%0b rdata=%h required %0d 1 0badf00d",
               dbg_state, inst_data_ok, inst_rdata, ST_WAIT);
    else passes++;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    int n, lat;
    logic [31:0] a;
    inst_req = 1'b1; inst_addr = 32'h1C00_00C0;
    wait_mem_req(n);
    mem_addr_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_WAIT) $display("FAIL pre_reset_state: got %0d required %0d", dbg_state, ST_WAIT);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) $display("FAIL reset_mid_wait_outputs: got %h required 0", all_outs);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = $urandom;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00)
      $display("FAIL stale_return_after_reset: got %0b%0b required 00", inst_data_ok, data_data_ok);
    else passes++;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    a = $urandom;
    push_data(1'b0, 2'd1, 4'h3, a, 32'h0, $urandom);
    drive_data(1'b0, 2'd1, 4'h3, a, 32'h0);
    serve(1, 1, lat);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;
    test_reset;
    test_inst_only;
    test_simultaneous;
    test_starvation;
    test_backpressure;
    test_spurious;
    test_accept_and_return;
    test_reset_mid_wait;
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2, SHALL set the consecutive data grants allowed while inst_req waits.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 inst_req  in  1  SHALL be the fetch request, held until inst_addr_ok.
REQ-005 inst_addr  in  32  SHALL be the fetch address; the request is read-only, word size.
REQ-006 inst_addr_ok / inst_data_ok  out  1/1  SHALL be the fetch request-accept and read-return strobes.
REQ-007 inst_rdata  out  32  SHALL be the fetched instruction, valid with inst_data_ok.
REQ-008 data_req, data_wr  in  1/1  SHALL be the load/store request, held until data_addr_ok, and its write flag.
REQ-009 data_size, data_wstrb  in  2/4  SHALL be the access size (0=byte, 1=half, 2=word) and byte enables.
REQ-010 data_addr, data_wdata  in  32/32  SHALL be the access address and store data.
REQ-011 data_addr_ok / data_data_ok  out  1/1, data_rdata  out  32  SHALL be the accept strobe, completion strobe and load data.
REQ-012 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  SHALL drive the shared memory port.
REQ-013 mem_addr_ok, mem_data_ok  in  1/1, mem_rdata  in  32  SHALL be the shared-port responses.

Function
REQ-014 The block SHALL be a 3-state FSM: IDLE, REQ, WAIT; exactly one transaction outstanding on the memory port.
REQ-015 IDLE: on any request the block SHALL grant one requester, latch its fields (inst: wr=0, size=2, wstrb=0, wdata=0) and an owner bit, and enter REQ next cycle.
REQ-016 Grant priority SHALL be data over inst, except when starve_cnt == STARVE_LIMIT and inst_req=1, in which case inst SHALL be granted.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant with inst_req=1, and clear on any inst grant or any data grant with inst_req=0.
REQ-018 REQ: mem_req=1 with latched fields; on mem_addr_ok the owner's addr_ok SHALL pulse 1 that cycle and the state SHALL become WAIT.
REQ-019 WAIT: on mem_data_ok the owner's data_ok SHALL pulse 1 that cycle with rdata = mem_rdata, and state SHALL return to IDLE.
REQ-020 Minimum transaction cost SHALL be 3 cycles (grant, accept, return); back-to-back grants SHALL start in the IDLE cycle following return.
REQ-021 Non-owner addr_ok/data_ok SHALL stay 0; mem_req SHALL be 0 outside REQ.
REQ-022 mem_data_ok in IDLE or REQ SHALL be ignored (no strobe, no state change).
REQ-023 Requester deasserting req during REQ SHALL NOT cancel the latched transaction.
REQ-024 inst_rdata and data_rdata SHALL equal mem_rdata when their data_ok is 1 and are don't-care otherwise.
REQ-025 mem_addr_ok and mem_data_ok both 1 in REQ SHALL be treated as accept only.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, starve_cnt=0, owner=inst, latched fields 0, all outputs 0, abandoning any outstanding transaction.
REQ-027 After reset release, the first grant SHALL occur on the first rising edge with a request present.

Verification
REQ-028 Inst only: inst_req=1, addr=0x1C000000, mem_addr_ok next cycle, mem_data_ok=1 with rdata=0x02800C0C one cycle later -> inst_addr_ok at cycle 1, inst_data_ok with 0x02800C0C at cycle 2.
REQ-029 Simultaneous: inst_req=data_req=1, data store addr=0x1C001000, wstrb=0xF, wdata=0xDEADBEEF -> mem shows wr=1 with those values first; inst granted in the following IDLE.
REQ-030 Starvation: data_req held high with inst_req=1, STARVE_LIMIT=2 -> grant order data, data, inst, data.
REQ-031 Backpressure: mem_addr_ok held 0 for 5 cycles in REQ -> mem_req and fields stable 5 cycles, no addr_ok to requester.
REQ-032 Spurious return: mem_data_ok=1 in IDLE -> no data_ok on either port, state unchanged.
REQ-033 Reset mid-WAIT: assert reset during WAIT -> all outputs 0 at once; later mem_data_ok produces no strobe; new request served normally.
